// File: rtl/bus_burst_ram_slave_if.sv
// rtl/bus_burst_ram_slave_if.sv - burst bus between DMA master and RAM slave
interface bus_burst_ram_slave_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busErrorOut;
    logic        busyOut;

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
    );

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
    );
endinterface

// File: rtl/bus_burst_ram_slave.sv
// rtl/bus_burst_ram_slave.sv - windowed burst RAM slave; optional BUSY_INJECT_EN write back-pressure
module bus_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDR       = 32'h5000_0000,
    parameter int          ADDR_WORDS_LOG2 = 10,
    parameter int          READ_LATENCY    = 2
) (
    input logic                    clock,
    input logic                    reset,
    bus_burst_ram_slave_if.slave   bus
);
    localparam int AW    = ADDR_WORDS_LOG2;
    localparam int WORDS = 2 ** AW;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_BURST, RD_END, WR_BURST, ERR, ERR_END
    } state_t;

    state_t        state, state_next;
    logic [31:0]   mem [WORDS];
    logic [31:0]   rdata;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [8:0]    beat_cnt;
    logic [7:0]    burst_len;
    logic [3:0]    be;
    logic [2:0]    wait_cnt;
    logic          drop_err;
    logic          busy;

    logic [AW-1:0] begin_idx;
    logic [31:0]   last_idx;
    logic          selected;
    logic          begin_err;
    logic          start;
    logic          wr_accept;
    logic          wr_store;
    logic          wr_drop;
    logic          fetch;
    logic [AW-1:0] fetch_addr;

    assign begin_idx = bus.addressDataIn[AW+1:2];
    assign last_idx  = 32'(begin_idx) + 32'(bus.burstSizeIn);
    assign selected  = bus.beginTransactionIn &&
                       (bus.addressDataIn[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign begin_err = (bus.addressDataIn[1:0] != 2'b00) || (last_idx > 32'(WORDS - 1));
    assign start     = (state == IDLE) && selected;

    // beat_cnt counts stored beats during writes; extra beats past burst_len+1 are dropped
    assign wr_accept = (state == WR_BURST) && bus.dataValidIn && !busy;
    assign wr_store  = wr_accept && (beat_cnt <= {1'b0, burst_len});
    assign wr_drop   = wr_accept && !wr_store;

    // First word is fetched on the begin edge, then one word per beat so beats never gap
    assign fetch      = (start && bus.readNotWriteIn && !begin_err) || (state == RD_BURST);
    assign fetch_addr = (state == IDLE) ? begin_idx : rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (selected) begin
                    if (begin_err)
                        state_next = ERR;
                    else if (bus.readNotWriteIn)
                        state_next = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
                    else
                        state_next = WR_BURST;
                end
            end
            RD_WAIT:  if (wait_cnt == 3'd1) state_next = RD_BURST;
            RD_BURST: if (beat_cnt == 9'd0) state_next = RD_END;
            RD_END:   state_next = IDLE;
            WR_BURST: if (bus.endTransactionIn) state_next = IDLE;
            ERR:      state_next = ERR_END;
            ERR_END:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.dataValidOut      = (state == RD_BURST);
        bus.addressDataOut    = (state == RD_BURST) ? rdata : 32'h0;
        bus.endTransactionOut = (state == RD_END) || (state == ERR_END);
        bus.busErrorOut       = (state == ERR) || drop_err;
        bus.busyOut           = busy;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_idx    <= '0;
            beat_cnt  <= '0;
            burst_len <= '0;
            be        <= '0;
            wait_cnt  <= '0;
            drop_err  <= 1'b0;
        end else begin
            drop_err <= wr_drop;
            if (start) begin
                beat_cnt  <= bus.readNotWriteIn ? {1'b0, bus.burstSizeIn} : 9'd0;
                burst_len <= bus.burstSizeIn;
                be        <= bus.byteEnablesIn;
                wr_idx    <= begin_idx;
                rd_ptr    <= begin_idx + 1'b1;
                wait_cnt  <= 3'(READ_LATENCY - 1);
            end
            if (state == RD_WAIT)
                wait_cnt <= wait_cnt - 1'b1;
            if (state == RD_BURST) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (beat_cnt != 9'd0)
                    beat_cnt <= beat_cnt - 1'b1;
            end
            if (wr_store) begin
                wr_idx   <= wr_idx + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[wr_idx][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
            end
        end
        if (fetch)
            rdata <= mem[fetch_addr];
    end

`ifdef BUSY_INJECT_EN
    logic [1:0] acc_cnt;

    // One stall cycle after every fourth accepted write beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_cnt <= 2'd0;
            busy    <= 1'b0;
        end else begin
            busy <= wr_accept && (acc_cnt == 2'd3);
            if (start)
                acc_cnt <= 2'd0;
            else if (wr_accept)
                acc_cnt <= acc_cnt + 1'b1;
        end
    end
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_bus_burst_ram_slave.sv
// tb/tb_bus_burst_ram_slave.sv - directed bench for bus_burst_ram_slave
module tb_bus_burst_ram_slave;
`ifdef BUSY_INJECT_EN
    localparam bit BUSY_ON = 1'b1;
`else
    localparam bit BUSY_ON = 1'b0;
`endif

    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] expw  [16];
    logic [31:0] wdata [16];

    bus_burst_ram_slave_if bus ();

    bus_burst_ram_slave #(
        .BASE_ADDR       (32'h5000_0000),
        .ADDR_WORDS_LOG2 (10),
        .READ_LATENCY    (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.beginTransactionIn = 1'b0;
        bus.addressDataIn      = 32'h0;
        bus.readNotWriteIn     = 1'b0;
        bus.burstSizeIn        = 8'h0;
        bus.byteEnablesIn      = 4'h0;
        bus.dataValidIn        = 1'b0;
        bus.endTransactionIn   = 1'b0;
    endtask

    task automatic drive_begin(input logic [31:0] addr, input logic rnw,
                               input logic [7:0] burst, input logic [3:0] be);
        @(negedge clock);
        bus.beginTransactionIn = 1'b1;
        bus.addressDataIn      = addr;
        bus.readNotWriteIn     = rnw;
        bus.burstSizeIn        = burst;
        bus.byteEnablesIn      = be;
    endtask

    task automatic read_burst(input string tag, input logic [31:0] addr, input int n);
        drive_begin(addr, 1'b1, 8'(n - 1), 4'hF);
        @(negedge clock);
        idle_inputs();
        check({tag, "_wait_valid"}, 32'(bus.dataValidOut), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check({tag, "_valid"}, 32'(bus.dataValidOut), 32'd1);
            check({tag, "_data"}, bus.addressDataOut, expw[k]);
            check({tag, "_end_early"}, 32'(bus.endTransactionOut), 32'd0);
        end
        @(negedge clock);
        check({tag, "_end"}, 32'(bus.endTransactionOut), 32'd1);
        check({tag, "_end_valid"}, 32'(bus.dataValidOut), 32'd0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input int n, input logic [3:0] be,
                               input bit end_with_last);
        drive_begin(addr, 1'b0, 8'(n - 1), be);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            bus.beginTransactionIn = 1'b0;
            bus.dataValidIn        = 1'b1;
            bus.addressDataIn      = wdata[k];
            bus.endTransactionIn   = end_with_last && (k == n - 1);
        end
        if (!end_with_last) begin
            @(negedge clock);
            bus.dataValidIn      = 1'b0;
            bus.endTransactionIn = 1'b1;
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic err_begin(input string tag, input logic [31:0] addr, input logic [7:0] burst);
        drive_begin(addr, 1'b0, burst, 4'hF);
        @(negedge clock);
        bus.beginTransactionIn = 1'b0;
        bus.dataValidIn        = 1'b1;
        bus.addressDataIn      = 32'hFFFF_FFFF;
        check({tag, "_buserr"}, 32'(bus.busErrorOut), 32'd1);
        check({tag, "_end_early"}, 32'(bus.endTransactionOut), 32'd0);
        @(negedge clock);
        check({tag, "_buserr_clr"}, 32'(bus.busErrorOut), 32'd0);
        check({tag, "_end"}, 32'(bus.endTransactionOut), 32'd1);
        @(negedge clock);
        idle_inputs();
        check({tag, "_end_clr"}, 32'(bus.endTransactionOut), 32'd0);
    endtask

    initial begin
        int  acc;
        bit  exp_busy;
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outs", {27'd0, bus.dataValidOut, bus.endTransactionOut,
              bus.busErrorOut, bus.busyOut, 1'b0}, 32'd0);
        check("reset_data", bus.addressDataOut, 32'd0);
        reset = 1'b0;

        // 1: preload and read back four words
        for (int k = 0; k < 4; k++) wdata[k] = 32'(k + 1);
        write_burst(32'h5000_0000, 4, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) expw[k] = 32'(k + 1);
        read_burst("rd4", 32'h5000_0000, 4);

        // 2: two-beat write, then single-byte overwrite
        wdata[0] = 32'hAABB_CCDD;
        wdata[1] = 32'h1122_3344;
        write_burst(32'h5000_0010, 2, 4'hF, 1'b0);
        expw[0] = 32'hAABB_CCDD;
        expw[1] = 32'h1122_3344;
        read_burst("wr2", 32'h5000_0010, 2);
        wdata[0] = 32'h0;
        write_burst(32'h5000_0010, 1, 4'b0001, 1'b1);
        expw[0] = 32'hAABB_CC00;
        read_burst("wr_be", 32'h5000_0010, 1);

        // 3: misaligned and past-window bursts, RAM untouched
        err_begin("err_align", 32'h5000_0002, 8'd0);
        err_begin("err_range", 32'h5000_0FFC, 8'd1);
        for (int k = 0; k < 4; k++) expw[k] = 32'(k + 1);
        read_burst("err_ram", 32'h5000_0000, 4);

        // last word of the window is legal
        wdata[0] = 32'hDEAD_BEEF;
        write_burst(32'h5000_0FFC, 1, 4'hF, 1'b1);
        expw[0] = 32'hDEAD_BEEF;
        read_burst("top_word", 32'h5000_0FFC, 1);

        // 4: unselected begin is ignored
        drive_begin(32'h4000_0000, 1'b1, 8'd3, 4'hF);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            idle_inputs();
            check("unsel_ctl", {28'd0, bus.dataValidOut, bus.endTransactionOut,
                  bus.busErrorOut, bus.busyOut}, 32'd0);
            check("unsel_data", bus.addressDataOut, 32'd0);
        end
        for (int k = 0; k < 4; k++) expw[k] = 32'(k + 1);
        read_burst("unsel_rd", 32'h5000_0000, 4);

        // extra write beat is dropped and flagged
        drive_begin(32'h5000_0018, 1'b0, 8'd0, 4'hF);
        @(negedge clock);
        bus.beginTransactionIn = 1'b0;
        bus.dataValidIn   = 1'b1;
        bus.addressDataIn = 32'h0000_0011;
        @(negedge clock);
        bus.addressDataIn = 32'h0000_0022;
        check("drop_pre", 32'(bus.busErrorOut), 32'd0);
        @(negedge clock);
        bus.dataValidIn      = 1'b0;
        bus.endTransactionIn = 1'b1;
        check("drop_err", 32'(bus.busErrorOut), 32'd1);
        @(negedge clock);
        idle_inputs();
        check("drop_err_clr", 32'(bus.busErrorOut), 32'd0);
        expw[0] = 32'h0000_0011;
        read_burst("drop_ram", 32'h5000_0018, 1);

        // 5: reset during second beat of a read
        drive_begin(32'h5000_0000, 1'b1, 8'd3, 4'hF);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        check("rst_beat1", bus.addressDataOut, 32'd1);
        @(negedge clock);
        check("rst_beat2", bus.addressDataOut, 32'd2);
        reset = 1'b1;
        #1;
        check("rst_async_valid", 32'(bus.dataValidOut), 32'd0);
        check("rst_async_data", bus.addressDataOut, 32'd0);
        @(negedge clock);
        check("rst_hold_end", 32'(bus.endTransactionOut), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) expw[k] = 32'(k + 1);
        read_burst("rst_rd", 32'h5000_0000, 4);

        // 6: eight back-to-back write beats with optional back-pressure
        for (int k = 0; k < 8; k++) wdata[k] = 32'hC0DE_0000 + 32'(k);
        acc      = 0;
        exp_busy = 1'b0;
        drive_begin(32'h5000_0040, 1'b0, 8'd7, 4'hF);
        for (int c = 0; c < 20 && acc < 8; c++) begin
            @(negedge clock);
            bus.beginTransactionIn = 1'b0;
            check("busy", 32'(bus.busyOut), 32'(exp_busy));
            bus.dataValidIn   = 1'b1;
            bus.addressDataIn = wdata[acc];
            if (!exp_busy) begin
                acc++;
                exp_busy = BUSY_ON && (acc % 4 == 0);
            end else begin
                exp_busy = 1'b0;
            end
        end
        check("busy_beats", 32'(acc), 32'd8);
        @(negedge clock);
        bus.dataValidIn      = 1'b0;
        bus.endTransactionIn = 1'b1;
        check("busy_last", 32'(bus.busyOut), 32'(exp_busy));
        @(negedge clock);
        idle_inputs();
        check("busy_clr", 32'(bus.busyOut), 32'd0);
        for (int k = 0; k < 8; k++) expw[k] = wdata[k];
        read_burst("busy_rd", 32'h5000_0040, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
